multichannel_phase_accumulator: RTL and testbench

Time-multiplexed N-channel DDS phase accumulator for the tracker voice engine; successor to the single-channel accumulator.
- Holds per-channel frequency control words (FCW) and phases.
- On each sample tick, sweeps all channels, one per clock.
- Emits a truncated phase, channel index and wrap flag per channel to the waveform lookup stage.
- Adds per-channel retrigger, a busy indication and overrun detection.

---
 rtl/phase_acc_pkg.sv | 17 +
 rtl/phase_acc_regfile.sv | 47 ++++
 rtl/multichannel_phase_accumulator.sv | 200 ++++++++++++++++++++
 tb/tb_multichannel_phase_accumulator.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_acc_pkg.sv
// Shared types and default sizing for the multichannel DDS phase accumulator.
package phase_acc_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_t;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_PHASE_WIDTH = 24;
    localparam int DEF_OUT_WIDTH   = 10;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_acc_regfile.sv
// NUM_CH x WIDTH register array: one combinational read port, one write port
// and a clear port that overrides a same-address write.
module phase_acc_regfile
    import phase_acc_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WIDTH  = DEF_PHASE_WIDTH,
    parameter int AW     = ch_width(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr
);

    logic [WIDTH-1:0] mem_q [NUM_CH];
    logic [WIDTH-1:0] mem_d [NUM_CH];

    // Addresses at or above NUM_CH match no entry and are dropped.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
                mem_d[i] = wr_data;
            end
            if (clr_en && (clr_addr == AW'(i))) begin
                mem_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/multichannel_phase_accumulator.sv
// Time-multiplexed N-channel DDS phase accumulator: one channel per clock per sample tick.
// Optional hard sync between adjacent channels via `define PHASE_ACC_HARD_SYNC_EN.
module multichannel_phase_accumulator
    import phase_acc_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst_active_high,
    input  logic                   sample_tick,
    input  logic                   cfg_we,
    input  logic                   retrig_we,
    input  logic                   cfg_sync_we,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [PHASE_WIDTH-1:0] cfg_fcw,
    input  logic                   cfg_sync,
    input  logic                   overrun_clr,
    output logic                   out_valid,
    output logic [CH_W-1:0]        out_ch,
    output logic [OUT_WIDTH-1:0]   out_phase,
    output logic                   out_wrap,
    output logic                   busy,
    output logic                   overrun
);

    state_t                 state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic                   tick_q, tick_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   out_valid_q, out_valid_d;
    logic [CH_W-1:0]        out_ch_q, out_ch_d;
    logic [OUT_WIDTH-1:0]   out_phase_q, out_phase_d;
    logic                   out_wrap_q, out_wrap_d;

    logic                   cfg_in_range;
    logic                   sweeping;
    logic                   last_ch;
    logic [PHASE_WIDTH-1:0] fcw_rd;
    logic [PHASE_WIDTH-1:0] phase_rd;
    logic [PHASE_WIDTH:0]   sum;
    logic                   retrig_hit;
    logic                   sync_hit;
    logic                   beat_wrap;
    logic [PHASE_WIDTH-1:0] phase_wr;

    assign cfg_in_range = (int'(cfg_ch) < NUM_CH);
    assign sweeping     = (state_q == ST_SWEEP);
    assign last_ch      = (ch_q == CH_W'(NUM_CH - 1));

    phase_acc_regfile #(
        .NUM_CH (NUM_CH),
        .WIDTH  (PHASE_WIDTH),
        .AW     (CH_W)
    ) u_fcw (
        .clk      (clk),
        .rst      (rst_active_high),
        .rd_addr  (ch_q),
        .rd_data  (fcw_rd),
        .wr_en    (cfg_we && cfg_in_range),
        .wr_addr  (cfg_ch),
        .wr_data  (cfg_fcw),
        .clr_en   (1'b0),
        .clr_addr ('0)
    );

    phase_acc_regfile #(
        .NUM_CH (NUM_CH),
        .WIDTH  (PHASE_WIDTH),
        .AW     (CH_W)
    ) u_phase (
        .clk      (clk),
        .rst      (rst_active_high),
        .rd_addr  (ch_q),
        .rd_data  (phase_rd),
        .wr_en    (sweeping),
        .wr_addr  (ch_q),
        .wr_data  (phase_wr),
        .clr_en   (retrig_we && cfg_in_range),
        .clr_addr (cfg_ch)
    );

    assign sum        = {1'b0, phase_rd} + {1'b0, fcw_rd};
    assign retrig_hit = retrig_we && cfg_in_range && (cfg_ch == ch_q);
    assign phase_wr   = sync_hit ? '0 : sum[PHASE_WIDTH-1:0];
    assign beat_wrap  = retrig_hit ? 1'b0 : (sync_hit ? 1'b1 : sum[PHASE_WIDTH]);

`ifdef PHASE_ACC_HARD_SYNC_EN
    logic [NUM_CH-1:0] sync_en_q, sync_en_d;
    logic              wrap_prev_q, wrap_prev_d;

    // wrap_prev carries the previous beat's reported wrap within one sweep only.
    assign sync_hit = sweeping && (ch_q != '0) && sync_en_q[ch_q] && wrap_prev_q;

    always_comb begin
        sync_en_d = sync_en_q;
        if (cfg_sync_we && cfg_in_range) begin
            sync_en_d[cfg_ch] = cfg_sync;
        end
        wrap_prev_d = sweeping ? beat_wrap : 1'b0;
    end

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            sync_en_q   <= '0;
            wrap_prev_q <= 1'b0;
        end else begin
            sync_en_q   <= sync_en_d;
            wrap_prev_q <= wrap_prev_d;
        end
    end
`else
    logic unused_sync;
    assign unused_sync = cfg_sync_we ^ cfg_sync;
    assign sync_hit    = 1'b0;
`endif

    // The tick is registered once so the first beat lands two edges after it.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        busy_d      = busy_q;
        tick_d      = sample_tick && !busy_q && !tick_q;
        out_valid_d = 1'b0;
        out_ch_d    = '0;
        out_phase_d = '0;
        out_wrap_d  = 1'b0;

        overrun_d = overrun_q;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (sample_tick && busy_q) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick_q) begin
                    state_d = ST_SWEEP;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SWEEP: begin
                out_valid_d = 1'b1;
                out_ch_d    = ch_q;
                out_phase_d = (retrig_hit || sync_hit) ? '0 : sum[PHASE_WIDTH-1 -: OUT_WIDTH];
                out_wrap_d  = beat_wrap;
                if (last_ch) begin
                    state_d = ST_IDLE;
                    ch_d    = '0;
                    busy_d  = 1'b0;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_phase_q <= '0;
            out_wrap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_phase_q <= out_phase_d;
            out_wrap_q  <= out_wrap_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_phase = out_phase_q;
    assign out_wrap  = out_wrap_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_multichannel_phase_accumulator.sv
// Directed bench for multichannel_phase_accumulator at default sizing (4 ch, 24-bit, 10-bit out).
module tb_multichannel_phase_accumulator;

    logic        clk = 1'b0;
    logic        rst_active_high;
    logic        sample_tick;
    logic        cfg_we;
    logic        retrig_we;
    logic        cfg_sync_we;
    logic [1:0]  cfg_ch;
    logic [23:0] cfg_fcw;
    logic        cfg_sync;
    logic        overrun_clr;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [9:0]  out_phase;
    logic        out_wrap;
    logic        busy;
    logic        overrun;

    int passed = 0;
    int total  = 0;

    logic [1:0] bch [10];
    logic [9:0] bph [10];
    logic       bwr [10];
    int         nbeats;
    int         nbusy;

    always #5 clk = ~clk;

    multichannel_phase_accumulator #(
        .NUM_CH      (4),
        .PHASE_WIDTH (24),
        .OUT_WIDTH   (10)
    ) dut (
        .clk             (clk),
        .rst_active_high (rst_active_high),
        .sample_tick     (sample_tick),
        .cfg_we          (cfg_we),
        .retrig_we       (retrig_we),
        .cfg_sync_we     (cfg_sync_we),
        .cfg_ch          (cfg_ch),
        .cfg_fcw         (cfg_fcw),
        .cfg_sync        (cfg_sync),
        .overrun_clr     (overrun_clr),
        .out_valid       (out_valid),
        .out_ch          (out_ch),
        .out_phase       (out_phase),
        .out_wrap        (out_wrap),
        .busy            (busy),
        .overrun         (overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_active_high = 1'b1;
        step();
        step();
        rst_active_high = 1'b0;
        step();
    endtask

    task automatic write_fcw(input logic [1:0] ch, input logic [23:0] v);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_fcw = v;
        step();
        cfg_we  = 1'b0;
    endtask

    // Records every beat and busy cycle over a fixed window after the current cycle.
    task automatic observe(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            if (busy) nbusy++;
            if (out_valid) begin
                if (nbeats < 10) begin
                    bch[nbeats] = out_ch;
                    bph[nbeats] = out_phase;
                    bwr[nbeats] = out_wrap;
                end
                nbeats++;
            end
        end
    endtask

    task automatic run_sweep();
        nbeats = 0;
        nbusy  = 0;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        observe(10);
    endtask

    task automatic test_reset();
        rst_active_high = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passed++;
        total++; if (out_phase !== 10'h000) $display("FAIL reset_phase: got %h expected 000", out_phase); else passed++;
        total++; if (out_ch !== 2'd0) $display("FAIL reset_ch: got %0d expected 0", out_ch); else passed++;
        rst_active_high = 1'b0;
        step();
    endtask

    task automatic test_basic_sweep();
        write_fcw(2'd0, 24'h100000);
        run_sweep();
        total++; if (nbeats !== 4) $display("FAIL basic_beats: got %0d expected 4", nbeats); else passed++;
        total++; if (nbusy !== 4) $display("FAIL basic_busy_cycles: got %0d expected 4", nbusy); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bch[i] !== 2'(i)) $display("FAIL basic_ch_order[%0d]: got %0d expected %0d", i, bch[i], i);
            else passed++;
        end
        total++; if (bph[0] !== 10'h040) $display("FAIL basic_ch0_phase: got %h expected 040", bph[0]); else passed++;
        total++; if (bwr[0] !== 1'b0) $display("FAIL basic_ch0_wrap: got %b expected 0", bwr[0]); else passed++;
        for (int i = 1; i < 4; i++) begin
            total++;
            if (bph[i] !== 10'h000) $display("FAIL basic_zero_fcw_phase[%0d]: got %h expected 000", i, bph[i]);
            else passed++;
        end
    endtask

    task automatic test_half_scale_wrap();
        write_fcw(2'd1, 24'h800000);
        run_sweep();
        total++; if (bph[1] !== 10'h200) $display("FAIL half_s1_phase: got %h expected 200", bph[1]); else passed++;
        total++; if (bwr[1] !== 1'b0) $display("FAIL half_s1_wrap: got %b expected 0", bwr[1]); else passed++;
        total++; if (bph[0] !== 10'h080) $display("FAIL half_s1_ch0_phase: got %h expected 080", bph[0]); else passed++;
        run_sweep();
        total++; if (bph[1] !== 10'h000) $display("FAIL half_s2_phase: got %h expected 000", bph[1]); else passed++;
        total++; if (bwr[1] !== 1'b1) $display("FAIL half_s2_wrap: got %b expected 1", bwr[1]); else passed++;
    endtask

    task automatic test_overrun();
        nbeats = 0;
        nbusy  = 0;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        if (out_valid) nbeats++;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        if (out_valid) nbeats++;
        observe(14);
        total++; if (nbeats !== 4) $display("FAIL overrun_beats: got %0d expected 4", nbeats); else passed++;
        total++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun); else passed++;
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        total++; if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b expected 0", overrun); else passed++;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        sample_tick = 1'b1;
        overrun_clr = 1'b1;
        step();
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        total++; if (overrun !== 1'b1) $display("FAIL overrun_set_beats_clear: got %b expected 1", overrun); else passed++;
        observe(8);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
    endtask

    task automatic test_retrig_and_cfg_timing();
        do_reset();
        write_fcw(2'd2, 24'h100000);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        step();
        retrig_we = 1'b1;
        cfg_ch    = 2'd2;
        step();
        retrig_we = 1'b0;
        total++; if (out_ch !== 2'd2) $display("FAIL retrig_beat_ch: got %0d expected 2", out_ch); else passed++;
        total++; if (out_phase !== 10'h000) $display("FAIL retrig_beat_phase: got %h expected 000", out_phase); else passed++;
        total++; if (out_wrap !== 1'b0) $display("FAIL retrig_beat_wrap: got %b expected 0", out_wrap); else passed++;
        cfg_we  = 1'b1;
        cfg_ch  = 2'd3;
        cfg_fcw = 24'h200000;
        step();
        cfg_we  = 1'b0;
        total++; if (out_ch !== 2'd3) $display("FAIL cfg_same_cycle_ch: got %0d expected 3", out_ch); else passed++;
        total++; if (out_phase !== 10'h000) $display("FAIL cfg_same_cycle_old_fcw: got %h expected 000", out_phase); else passed++;
        observe(4);
        run_sweep();
        total++; if (bph[2] !== 10'h040) $display("FAIL retrig_next_phase: got %h expected 040", bph[2]); else passed++;
        total++; if (bph[3] !== 10'h080) $display("FAIL cfg_new_fcw_phase: got %h expected 080", bph[3]); else passed++;
    endtask

    task automatic test_reset_mid_sweep();
        write_fcw(2'd0, 24'h300000);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        step();
        #1 rst_active_high = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", out_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else passed++;
        total++; if (out_ch !== 2'd0) $display("FAIL midrst_ch: got %0d expected 0", out_ch); else passed++;
        step();
        rst_active_high = 1'b0;
        nbeats = 0;
        nbusy  = 0;
        observe(8);
        total++; if (nbeats !== 0) $display("FAIL midrst_no_resume: got %0d expected 0", nbeats); else passed++;
        run_sweep();
        total++; if (nbeats !== 4) $display("FAIL postrst_beats: got %0d expected 4", nbeats); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bch[i] !== 2'(i) || bph[i] !== 10'h000)
                $display("FAIL postrst_beat[%0d]: got ch %0d phase %h expected ch %0d phase 000", i, bch[i], bph[i], i);
            else passed++;
        end
    endtask

`ifdef PHASE_ACC_HARD_SYNC_EN
    task automatic test_hard_sync();
        do_reset();
        write_fcw(2'd0, 24'h800000);
        write_fcw(2'd1, 24'h100000);
        cfg_sync_we = 1'b1;
        cfg_ch      = 2'd1;
        cfg_sync    = 1'b1;
        step();
        cfg_sync_we = 1'b0;
        run_sweep();
        total++; if (bph[1] !== 10'h040) $display("FAIL sync_s1_ch1_phase: got %h expected 040", bph[1]); else passed++;
        run_sweep();
        total++; if (bwr[0] !== 1'b1) $display("FAIL sync_s2_ch0_wrap: got %b expected 1", bwr[0]); else passed++;
        total++; if (bph[1] !== 10'h000) $display("FAIL sync_s2_ch1_phase: got %h expected 000", bph[1]); else passed++;
        total++; if (bwr[1] !== 1'b1) $display("FAIL sync_s2_ch1_wrap: got %b expected 1", bwr[1]); else passed++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_active_high = 1'b0;
        sample_tick     = 1'b0;
        cfg_we          = 1'b0;
        retrig_we       = 1'b0;
        cfg_sync_we     = 1'b0;
        cfg_ch          = 2'd0;
        cfg_fcw         = 24'h0;
        cfg_sync        = 1'b0;
        overrun_clr     = 1'b0;
        nbeats          = 0;
        nbusy           = 0;
        #2;
        test_reset();
        test_basic_sweep();
        test_half_scale_wrap();
        test_overrun();
        test_retrig_and_cfg_timing();
        test_reset_mid_sweep();
`ifdef PHASE_ACC_HARD_SYNC_EN
        test_hard_sync();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
